series_sequencer: RTL and testbench

Control sequencer for the iterative series-evaluation datapath: accepts one operand `x` per job over a ready/valid handshake, then steps the datapath through `N_TERMS` term updates. It drives the load enables, step enable and feedback selects (`sel_x`, `sel_num`, `sel_sum`, `sel_i`) and tracks the term index. It reports completion with `out_valid`, or reports datapath overflow with `error`. It sits between the top-level job interface and the accumulator/term registers of the evaluator.

---
 rtl/series_sequencer.sv | 131 +++++++++++++
 tb/tb_series_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/series_sequencer.sv
// Control sequencer stepping the series datapath through N_TERMS term updates per job.
// Define SEQ_ABORT_EN to add the abort input, which returns any active job to IDLE.
module series_sequencer #(
    parameter int N_TERMS = 7,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             ovf,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             ld_x,
    output logic             ld_init,
    output logic             en_step,
    output logic             sel_x,
    output logic             sel_num,
    output logic             sel_sum,
    output logic             sel_i,
    output logic [CNT_W-1:0] i_cnt,
    output logic             busy,
    output logic             out_valid,
    output logic             error
);

    generate
        if (N_TERMS < 1 || N_TERMS >= (1 << CNT_W)) begin : g_bad_terms
            $error("series_sequencer: N_TERMS out of range for CNT_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITX,
        S_COMPUTE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state;
    state_t state_n;
    logic   abort_hit;

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_WAITX;
            end
            S_WAITX: begin
                if (in_valid) state_n = (N_TERMS == 1) ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (ovf) state_n = S_ERR;
                else if (i_cnt == LAST) state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            S_ERR: begin
                if (start) state_n = S_WAITX;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_hit) state_n = S_IDLE;
    end

    always_comb begin
        ready     = 1'b0;
        en_step   = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        error     = 1'b0;
        unique case (state)
            S_WAITX: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            S_COMPUTE: begin
                en_step = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // All feedback selects follow the step enable.
    assign sel_x   = en_step;
    assign sel_num = en_step;
    assign sel_sum = en_step;
    assign sel_i   = en_step;
    assign ld_x    = ready && in_valid;
    assign ld_init = ld_x;

    // The increment on the final step lands on N_TERMS, which still fits CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt <= '0;
        end else if (state_n == S_IDLE) begin
            i_cnt <= '0;
        end else if (ld_init) begin
            i_cnt <= ONE;
        end else if (state == S_COMPUTE && !ovf) begin
            i_cnt <= i_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_series_sequencer.sv
// Bench for series_sequencer: directed and random jobs against a job-level model.
// Abort cases are exercised when SEQ_ABORT_EN is defined.
module tb_series_sequencer;

    localparam int N = 7;

    logic clk = 1'b0;
    logic rst, start, in_valid, ovf, abort_v;
    logic ready, ld_x, ld_init, en_step, sel_x, sel_num, sel_sum, sel_i;
    logic busy, out_valid, error;
    logic [2:0] i_cnt;

    logic start1, in_valid1, ovf1, abort1;
    logic ready1, ld_x1, ld_init1, en_step1, sx1, sn1, ss1, si1;
    logic busy1, out_valid1, error1;
    logic [2:0] i_cnt1;

    int n_chk = 0;
    int n_fail = 0;
    logic       m_err;
    logic [2:0] m_cnt;

    always #5 clk = ~clk;

    series_sequencer #(.N_TERMS(N), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .ovf(ovf),
`ifdef SEQ_ABORT_EN
        .abort(abort_v),
`endif
        .ready(ready), .ld_x(ld_x), .ld_init(ld_init), .en_step(en_step),
        .sel_x(sel_x), .sel_num(sel_num), .sel_sum(sel_sum), .sel_i(sel_i),
        .i_cnt(i_cnt), .busy(busy), .out_valid(out_valid), .error(error)
    );

    series_sequencer #(.N_TERMS(1), .CNT_W(3)) u_one (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .ovf(ovf1),
`ifdef SEQ_ABORT_EN
        .abort(abort1),
`endif
        .ready(ready1), .ld_x(ld_x1), .ld_init(ld_init1), .en_step(en_step1),
        .sel_x(sx1), .sel_num(sn1), .sel_sum(ss1), .sel_i(si1),
        .i_cnt(i_cnt1), .busy(busy1), .out_valid(out_valid1), .error(error1)
    );

    wire [10:0] obs = {ready, ld_x, ld_init, en_step, sel_x, sel_num,
                       sel_sum, sel_i, busy, out_valid, error};
    wire [10:0] obs1 = {ready1, ld_x1, ld_init1, en_step1, sx1, sn1,
                        ss1, si1, busy1, out_valid1, error1};

    function automatic logic [10:0] ev(input logic rdy, input logic ldx,
                                       input logic stp, input logic bsy,
                                       input logic ov, input logic er);
        return {rdy, ldx, ldx, stp, stp, stp, stp, stp, bsy, ov, er};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input string tag, input logic [10:0] e, input logic [2:0] ec);
        @(negedge clk);
        n_chk++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s outputs: got %b expected %b", tag, obs, e);
        end
        n_chk++;
        assert (i_cnt === ec) else begin
            n_fail++;
            $error("FAIL %s i_cnt: got %0d expected %0d", tag, i_cnt, ec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input string tag, input logic [10:0] e, input logic [2:0] ec);
        @(negedge clk);
        n_chk++;
        assert (obs1 === e) else begin
            n_fail++;
            $error("FAIL %s outputs: got %b expected %b", tag, obs1, e);
        end
        n_chk++;
        assert (i_cnt1 === ec) else begin
            n_fail++;
            $error("FAIL %s i_cnt: got %0d expected %0d", tag, i_cnt1, ec);
        end
        @(posedge clk);
        #1;
    endtask

    // One job: gap idle cycles, start, wd waiting cycles, accept, then steps.
    // ovf_s/rst_s/ab_s pick the step (1..N-1) where that event happens; 0 = never.
    // ab_w: 0 none, 1 abort in WAITX, 2 abort at step ab_s.
    task automatic run_job(input int gap, input int wd, input int ovf_s,
                           input int rst_s, input int ab_w, input int ab_s);
        for (int g = 0; g < gap; g++) begin
            start = 1'b0; in_valid = rbit(); ovf = rbit();
            cyc("idle", ev(0, 0, 0, 0, 0, m_err), m_cnt);
        end
        start = 1'b1; in_valid = rbit(); ovf = rbit();
        cyc("start", ev(0, 0, 0, 0, 0, m_err), m_cnt);
        start = 1'b0; ovf = 1'b0;
        if (ab_w == 1) begin
            in_valid = 1'b0; abort_v = 1'b1;
            cyc("waitx_abort", ev(1, 0, 0, 1, 0, 0), m_cnt);
            abort_v = 1'b0; m_err = 1'b0; m_cnt = '0;
            return;
        end
        for (int w = 0; w < wd; w++) begin
            start = rbit(); in_valid = 1'b0; ovf = rbit();
            cyc("waitx", ev(1, 0, 0, 1, 0, 0), m_cnt);
        end
        start = rbit(); in_valid = 1'b1; ovf = rbit();
        cyc("accept", ev(1, 1, 0, 1, 0, 0), m_cnt);
        m_err = 1'b0; m_cnt = 3'd1;
        for (int s = 1; s < N; s++) begin
            start = rbit(); in_valid = rbit();
            ovf = (s == ovf_s);
            rst = (s == rst_s);
            abort_v = (ab_w == 2 && s == ab_s);
            cyc("compute", ev(0, 0, 1, 1, 0, 0), 3'(s));
            if (rst || abort_v) begin
                rst = 1'b0; abort_v = 1'b0; ovf = 1'b0;
                m_cnt = '0; m_err = 1'b0;
                return;
            end
            if (ovf) begin
                ovf = 1'b0; m_err = 1'b1; m_cnt = 3'(s);
                return;
            end
        end
        // A start during DONE must be lost.
        start = 1'b1; in_valid = rbit(); ovf = rbit();
        cyc("done", ev(0, 0, 0, 1, 1, 0), 3'(N));
        start = 1'b0;
        m_cnt = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; ovf = 1'b0; abort_v = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b1; ovf1 = 1'b0; abort1 = 1'b0;
        m_err = 1'b0; m_cnt = '0;
        @(posedge clk);
        #1;
        cyc("reset", ev(0, 0, 0, 0, 0, 0), 3'd0);
        rst = 1'b0;

        run_job(1, 2, 0, 0, 0, 0);
        run_job(0, 1, 3, 0, 0, 0);
        run_job(3, 0, 0, 0, 0, 0);
        run_job(1, 1, 0, 4, 0, 0);
        run_job(1, 0, 0, 0, 0, 0);
        run_job(1, 0, N - 1, 0, 0, 0);
        run_job(2, 2, 1, 0, 0, 0);
`ifdef SEQ_ABORT_EN
        run_job(1, 1, 0, 0, 1, 0);
        run_job(1, 0, 0, 0, 2, 3);
        run_job(1, 0, 2, 0, 2, 2);
        run_job(1, 0, 0, 0, 0, 0);
`endif

        for (int j = 0; j < 30; j++) begin
            int ov_s;
            ov_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : 0;
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    ov_s, 0, 0, 0);
        end

        // Single-term instance: in_valid1 has been high throughout idle.
        cyc1("one_idle", ev(0, 0, 0, 0, 0, 0), 3'd0);
        start1 = 1'b1; in_valid1 = 1'b0;
        cyc1("one_start", ev(0, 0, 0, 0, 0, 0), 3'd0);
        start1 = 1'b0;
        cyc1("one_waitx", ev(1, 0, 0, 1, 0, 0), 3'd0);
        in_valid1 = 1'b1;
        cyc1("one_accept", ev(1, 1, 0, 1, 0, 0), 3'd0);
        in_valid1 = 1'b0;
        cyc1("one_done", ev(0, 0, 0, 1, 1, 0), 3'd1);
        cyc1("one_back", ev(0, 0, 0, 0, 0, 0), 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
